// File: rtl/axis_1553_pkg.sv
// Shared constants and state encoding for the two-source MIL-STD-1553 message arbiter.
package axis_1553_pkg;

   localparam logic [7:0] CMD_SYNC  = 8'h81;
   localparam logic [7:0] DATA_SYNC = 8'h41;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/axis_1553_arb_timer.sv
// Loadable down-counter with a zero flag; times both the inter-message gap and the
// mid-message stall limit.
module axis_1553_arb_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [WIDTH-1:0] count_r;

   // Load has priority over decrement; the count parks at zero instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {WIDTH{1'b0}})) begin
         count_r <= count_r - WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/axis_1553_msg_arbiter.sv
// Round-robin arbiter merging two 1553 message streams onto one encoder stream with an
// enforced inter-message gap. Define AXIS_1553_ARB_TIMEOUT_EN to abandon stalled messages.
module axis_1553_msg_arbiter
   import axis_1553_pkg::*;
#(
   parameter int GAP_CYCLES     = 80,
   parameter int MAX_WORDS      = 33,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        aclk,
   input  logic        arstn,
   input  logic [15:0] s0_axis_tdata,
   input  logic [7:0]  s0_axis_tuser,
   input  logic        s0_axis_tvalid,
   input  logic        s0_axis_tlast,
   output logic        s0_axis_tready,
   input  logic [15:0] s1_axis_tdata,
   input  logic [7:0]  s1_axis_tuser,
   input  logic        s1_axis_tvalid,
   input  logic        s1_axis_tlast,
   output logic        s1_axis_tready,
   output logic [15:0] m_axis_tdata,
   output logic [7:0]  m_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        err_sync,
   output logic        err_len,
   output logic        err_timeout
);

   localparam int CW   = $clog2(MAX_WORDS + 1);
   localparam int TMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_WORDS - 1);
   localparam arb_state_t    AFTER_MSG = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef AXIS_1553_ARB_TIMEOUT_EN
   localparam logic [TW-1:0] TO_LOAD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

   arb_state_t    state_r, state_s;
   logic [1:0]    grant_r, grant_s;
   logic          last_r, last_s;
   logic [CW-1:0] beat_r, beat_s;
   logic          err_sync_r, err_sync_s;
   logic          err_len_r, err_len_s;
   logic          fwd_s, rdy_s, first_ok_s;
   logic          sel_valid_s, sel_last_s;
   logic [15:0]   sel_data_s;
   logic [7:0]    sel_user_s;
   logic          timer_load_s, timer_dec_s, timer_done_s;
   logic [TW-1:0] timer_val_s;
`ifdef AXIS_1553_ARB_TIMEOUT_EN
   logic          err_timeout_r, err_timeout_s;
`endif

   // Select the owning requester; with no owner every field reads as zero.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = 16'h0000;
      sel_user_s  = 8'h00;
      case (grant_r)
         2'b01: begin
            sel_valid_s = s0_axis_tvalid;
            sel_last_s  = s0_axis_tlast;
            sel_data_s  = s0_axis_tdata;
            sel_user_s  = s0_axis_tuser;
         end
         2'b10: begin
            sel_valid_s = s1_axis_tvalid;
            sel_last_s  = s1_axis_tlast;
            sel_data_s  = s1_axis_tdata;
            sel_user_s  = s1_axis_tuser;
         end
         default: begin
            sel_valid_s = 1'b0;
         end
      endcase
   end

   assign first_ok_s = (beat_r != {CW{1'b0}}) || (sel_user_s == CMD_SYNC);

   // Next-state, ownership, beat counting and handshake steering.
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      last_s       = last_r;
      beat_s       = beat_r;
      fwd_s        = 1'b0;
      rdy_s        = 1'b0;
      err_sync_s   = 1'b0;
      err_len_s    = 1'b0;
      timer_load_s = 1'b0;
      timer_val_s  = GAP_LOAD;
      timer_dec_s  = 1'b0;
`ifdef AXIS_1553_ARB_TIMEOUT_EN
      err_timeout_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (s0_axis_tvalid || s1_axis_tvalid) begin
               state_s = ST_XFER;
               beat_s  = {CW{1'b0}};
               // last_r=1 means s1 was served last, so s0 wins a tie.
               if (s0_axis_tvalid && (!s1_axis_tvalid || last_r)) begin
                  grant_s = 2'b01;
                  last_s  = 1'b0;
               end else begin
                  grant_s = 2'b10;
                  last_s  = 1'b1;
               end
`ifdef AXIS_1553_ARB_TIMEOUT_EN
               timer_load_s = 1'b1;
               timer_val_s  = TO_LOAD;
`endif
            end else begin
               grant_s = 2'b00;
            end
         end
         ST_XFER: begin
            if (!sel_valid_s) begin
`ifdef AXIS_1553_ARB_TIMEOUT_EN
               if (timer_done_s) begin
                  err_timeout_s = 1'b1;
                  state_s       = AFTER_MSG;
                  grant_s       = 2'b00;
                  beat_s        = {CW{1'b0}};
                  timer_load_s  = 1'b1;
               end else begin
                  timer_dec_s = 1'b1;
               end
`else
               state_s = ST_XFER;
`endif
            end else if (!first_ok_s) begin
               err_sync_s = 1'b1;
               state_s    = ST_DRAIN;
               beat_s     = {CW{1'b0}};
            end else begin
               fwd_s = 1'b1;
               rdy_s = m_axis_tready;
`ifdef AXIS_1553_ARB_TIMEOUT_EN
               timer_load_s = 1'b1;
               timer_val_s  = TO_LOAD;
`endif
               if (m_axis_tready) begin
                  if (sel_last_s) begin
                     state_s      = AFTER_MSG;
                     grant_s      = 2'b00;
                     beat_s       = {CW{1'b0}};
                     timer_load_s = 1'b1;
                     timer_val_s  = GAP_LOAD;
                  end else if (beat_r == LAST_BEAT) begin
                     err_len_s = 1'b1;
                     state_s   = ST_DRAIN;
                     beat_s    = {CW{1'b0}};
                  end else begin
                     beat_s = beat_r + CW'(1);
                  end
               end else begin
                  beat_s = beat_r;
               end
            end
         end
         ST_DRAIN: begin
            rdy_s = 1'b1;
            if (sel_valid_s && sel_last_s) begin
               state_s      = AFTER_MSG;
               grant_s      = 2'b00;
               beat_s       = {CW{1'b0}};
               timer_load_s = 1'b1;
               timer_val_s  = GAP_LOAD;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_GAP: begin
            grant_s = 2'b00;
            if (timer_done_s) begin
               state_s = ST_IDLE;
            end else begin
               timer_dec_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = 2'b00;
            beat_s  = {CW{1'b0}};
         end
      endcase
   end

   // Arbitration state, ownership, round-robin pointer, beat position and error pulses.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_r    <= ST_IDLE;
         grant_r    <= 2'b00;
         last_r     <= 1'b1;
         beat_r     <= {CW{1'b0}};
         err_sync_r <= 1'b0;
         err_len_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         grant_r    <= grant_s;
         last_r     <= last_s;
         beat_r     <= beat_s;
         err_sync_r <= err_sync_s;
         err_len_r  <= err_len_s;
      end
   end

`ifdef AXIS_1553_ARB_TIMEOUT_EN
   // Stall-expiry pulse register.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         err_timeout_r <= 1'b0;
      end else begin
         err_timeout_r <= err_timeout_s;
      end
   end
   assign err_timeout = err_timeout_r;
`else
   assign err_timeout = 1'b0;
`endif

   axis_1553_arb_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk      (aclk),
      .rst_n    (arstn),
      .load     (timer_load_s),
      .load_val (timer_val_s),
      .dec      (timer_dec_s),
      .done     (timer_done_s)
   );

   assign m_axis_tvalid  = fwd_s;
   assign m_axis_tdata   = sel_data_s;
   assign m_axis_tuser   = sel_user_s;
   assign s0_axis_tready = grant_r[0] & rdy_s;
   assign s1_axis_tready = grant_r[1] & rdy_s;
   assign grant          = grant_r;
   assign busy           = (state_r != ST_IDLE);
   assign err_sync       = err_sync_r;
   assign err_len        = err_len_r;

endmodule

// File: tb/tb_axis_1553_msg_arbiter.sv
// Directed bench for axis_1553_msg_arbiter: queue-fed source drivers, an output monitor,
// and hand-computed expectations for default parameters.
module tb_axis_1553_msg_arbiter;

   typedef struct packed {
      logic [15:0] d;
      logic [7:0]  u;
      logic        l;
   } beat_t;

   logic        aclk, arstn;
   logic [15:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
   logic [7:0]  s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
   logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
   logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
   logic        m_axis_tvalid, m_axis_tready;
   logic [1:0]  grant;
   logic        busy, err_sync, err_len, err_timeout;

   beat_t       q0[$];
   beat_t       q1[$];
   logic [15:0] out_data[$];
   logic [7:0]  out_user[$];
   logic [1:0]  out_grant[$];
   int          n_tests, n_fail, n_sync, n_len, n_to, gap_cnt, len_at;
   logic [1:0]  to_grant;

   axis_1553_msg_arbiter dut (
      .aclk           (aclk),
      .arstn          (arstn),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tuser  (s0_axis_tuser),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tuser  (s1_axis_tuser),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .grant          (grant),
      .busy           (busy),
      .err_sync       (err_sync),
      .err_len        (err_len),
      .err_timeout    (err_timeout)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
      #1;
   endtask

   task automatic push(input int src, input logic [15:0] d, input logic [7:0] u, input logic l);
      beat_t b;
      b.d = d;
      b.u = u;
      b.l = l;
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
   endtask

   task automatic clear_obs();
      out_data.delete();
      out_user.delete();
      out_grant.delete();
      n_sync = 0; n_len = 0; n_to = 0; gap_cnt = 0; len_at = -1;
      to_grant = 2'b11;
   endtask

   task automatic wait_out(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && out_data.size() < n; k++) tick();
      check_eq(tag, out_data.size(), n);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (!busy && q0.size() == 0 && q1.size() == 0) break;
         tick();
      end
      check_eq(tag, {31'd0, busy}, 32'd0);
   endtask

   // Source 0 driver: pop on the handshake seen mid-cycle, present the next beat after the edge.
   initial begin : drv0
      logic hs;
      forever begin
         @(negedge aclk);
         hs = s0_axis_tvalid && s0_axis_tready;
         @(posedge aclk);
         #1;
         if (hs && arstn && q0.size() > 0) q0.delete(0);
         if (q0.size() > 0) begin
            s0_axis_tvalid = 1'b1;
            s0_axis_tdata  = q0[0].d;
            s0_axis_tuser  = q0[0].u;
            s0_axis_tlast  = q0[0].l;
         end else begin
            s0_axis_tvalid = 1'b0;
         end
      end
   end

   initial begin : drv1
      logic hs;
      forever begin
         @(negedge aclk);
         hs = s1_axis_tvalid && s1_axis_tready;
         @(posedge aclk);
         #1;
         if (hs && arstn && q1.size() > 0) q1.delete(0);
         if (q1.size() > 0) begin
            s1_axis_tvalid = 1'b1;
            s1_axis_tdata  = q1[0].d;
            s1_axis_tuser  = q1[0].u;
            s1_axis_tlast  = q1[0].l;
         end else begin
            s1_axis_tvalid = 1'b0;
         end
      end
   end

   initial begin : mon
      forever begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tready) begin
            out_data.push_back(m_axis_tdata);
            out_user.push_back(m_axis_tuser);
            out_grant.push_back(grant);
         end
         if (err_sync) n_sync++;
         if (err_len) begin
            n_len++;
            len_at = out_data.size();
         end
         if (err_timeout) begin
            n_to++;
            to_grant = grant;
         end
         if (busy && grant == 2'b00) gap_cnt++;
      end
   end

   initial begin : main
      logic [15:0] exp_order [8];
      n_tests = 0; n_fail = 0;
      arstn = 1'b0; m_axis_tready = 1'b1;
      s0_axis_tvalid = 1'b0; s0_axis_tdata = 16'h0; s0_axis_tuser = 8'h0; s0_axis_tlast = 1'b0;
      s1_axis_tvalid = 1'b0; s1_axis_tdata = 16'h0; s1_axis_tuser = 8'h0; s1_axis_tlast = 1'b0;
      clear_obs();
      repeat (3) tick();

      check_eq("rst_grant", {30'd0, grant}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check_eq("rst_treadys", {30'd0, s1_axis_tready, s0_axis_tready}, 32'd0);
      check_eq("rst_errs", {29'd0, err_sync, err_len, err_timeout}, 32'd0);
      arstn = 1'b1;
      tick();

      // Single 3-beat message, then a second one to time the gap.
      clear_obs();
      push(0, 16'h1001, 8'h81, 1'b0); push(0, 16'h1002, 8'h41, 1'b0); push(0, 16'h1003, 8'h41, 1'b1);
      push(0, 16'h1011, 8'h81, 1'b0); push(0, 16'h1012, 8'h41, 1'b0); push(0, 16'h1013, 8'h41, 1'b1);
      wait_out("t1_first_msg", 3, 50);
      gap_cnt = 0;
      wait_out("t1_second_msg", 6, 200);
      check_eq("t1_gap_cycles", gap_cnt, 32'd80);
      check_eq("t1_beat0", {16'd0, out_data[0]}, 32'h1001);
      check_eq("t1_beat0_user", {24'd0, out_user[0]}, 32'h81);
      check_eq("t1_beat2", {16'd0, out_data[2]}, 32'h1003);
      check_eq("t1_beat2_user", {24'd0, out_user[2]}, 32'h41);
      check_eq("t1_grant", {30'd0, out_grant[1]}, 32'd1);
      wait_idle("t1_idle", 200);

      // Tie right after reset: s0 first, then alternate.
      arstn = 1'b0;
      push(0, 16'hA001, 8'h81, 1'b0); push(0, 16'hA002, 8'h41, 1'b1);
      push(0, 16'hA011, 8'h81, 1'b0); push(0, 16'hA012, 8'h41, 1'b1);
      push(1, 16'hB001, 8'h81, 1'b0); push(1, 16'hB002, 8'h41, 1'b1);
      push(1, 16'hB011, 8'h81, 1'b0); push(1, 16'hB012, 8'h41, 1'b1);
      repeat (2) tick();
      clear_obs();
      arstn = 1'b1;
      exp_order = '{16'hA001, 16'hA002, 16'hB001, 16'hB002, 16'hA011, 16'hA012, 16'hB011, 16'hB012};
      wait_out("t2_count", 8, 1000);
      for (int i = 0; i < 8 && i < out_data.size(); i++)
         check_eq($sformatf("t2_order%0d", i), {16'd0, out_data[i]}, {16'd0, exp_order[i]});
      check_eq("t2_grant_s1", {30'd0, out_grant[2]}, 32'd2);
      wait_idle("t2_idle", 200);

      // s1 sends a message with a bad command sync; s0 follows after the gap.
      clear_obs();
      push(1, 16'hC001, 8'h41, 1'b0); push(1, 16'hC002, 8'h41, 1'b0); push(1, 16'hC003, 8'h41, 1'b1);
      for (int k = 0; k < 50 && grant != 2'b10; k++) tick();
      check_eq("t3_s1_granted", {30'd0, grant}, 32'd2);
      push(0, 16'hD001, 8'h81, 1'b0); push(0, 16'hD002, 8'h41, 1'b1);
      wait_out("t3_count", 2, 300);
      check_eq("t3_err_sync", n_sync, 32'd1);
      check_eq("t3_first", {16'd0, out_data[0]}, 32'hD001);
      check_eq("t3_grant", {30'd0, out_grant[0]}, 32'd1);
      check_eq("t3_s1_drained", q1.size(), 32'd0);
      wait_idle("t3_idle", 200);

      // Over-long message: 35 beats, only 33 forwarded.
      clear_obs();
      for (int i = 0; i < 35; i++)
         push(0, 16'h5000 + 16'(i), (i == 0) ? 8'h81 : 8'h41, (i == 34) ? 1'b1 : 1'b0);
      wait_idle("t4_idle", 400);
      check_eq("t4_forwarded", out_data.size(), 32'd33);
      check_eq("t4_err_len", n_len, 32'd1);
      check_eq("t4_err_len_at", len_at, 32'd33);
      if (out_data.size() >= 33) check_eq("t4_beat33", {16'd0, out_data[32]}, 32'h5020);
      else check_eq("t4_beat33_missing", out_data.size(), 32'd33);

      // Stall after beat 2.
      clear_obs();
      push(0, 16'h6001, 8'h81, 1'b0); push(0, 16'h6002, 8'h41, 1'b0);
      wait_out("t5_two_beats", 2, 50);
      repeat (1100) tick();
`ifdef AXIS_1553_ARB_TIMEOUT_EN
      check_eq("t5_err_timeout", n_to, 32'd1);
      check_eq("t5_gap_grant", {30'd0, to_grant}, 32'd0);
      push(0, 16'h6003, 8'h41, 1'b0); push(0, 16'h6004, 8'h41, 1'b1);
      wait_idle("t5_idle", 300);
      check_eq("t5_leftover_sync", n_sync, 32'd1);
      check_eq("t5_forwarded", out_data.size(), 32'd2);
`else
      check_eq("t5_no_timeout", n_to, 32'd0);
      check_eq("t5_still_busy", {31'd0, busy}, 32'd1);
      check_eq("t5_still_granted", {30'd0, grant}, 32'd1);
      push(0, 16'h6003, 8'h41, 1'b0); push(0, 16'h6004, 8'h41, 1'b1);
      wait_out("t5_resume", 4, 50);
      if (out_data.size() >= 4) check_eq("t5_beat4", {16'd0, out_data[3]}, 32'h6004);
      else check_eq("t5_beat4_missing", out_data.size(), 32'd4);
      wait_idle("t5_idle", 200);
`endif

      // Reset while beat 2 of a 5-beat message is on the bus.
      clear_obs();
      push(0, 16'h7001, 8'h81, 1'b0);
      for (int i = 2; i <= 5; i++) push(0, 16'h7000 + 16'(i), 8'h41, (i == 5) ? 1'b1 : 1'b0);
      wait_out("t6_beat1", 1, 50);
      tick();
      check_eq("t6_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check_eq("t6_pre_data", {16'd0, m_axis_tdata}, 32'h7002);
      arstn = 1'b0;
      #1;
      check_eq("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check_eq("t6_rst_data", {16'd0, m_axis_tdata}, 32'd0);
      check_eq("t6_rst_tready", {30'd0, s1_axis_tready, s0_axis_tready}, 32'd0);
      check_eq("t6_rst_grant_busy", {29'd0, grant, busy}, 32'd0);
      q0.delete();
      q1.delete();
      repeat (3) tick();
      arstn = 1'b1;
      clear_obs();
      push(0, 16'h7101, 8'h81, 1'b0); push(0, 16'h7102, 8'h41, 1'b1);
      wait_out("t6_new_msg", 2, 50);
      if (out_data.size() >= 2) begin
         check_eq("t6_new_cmd", {16'd0, out_data[0]}, 32'h7101);
         check_eq("t6_new_data", {16'd0, out_data[1]}, 32'h7102);
      end else begin
         check_eq("t6_new_missing", out_data.size(), 32'd2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
